// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, LATENCY wait cycles, done pulse.
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range word index suppresses writes, returns zero and flags err.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        sByte,
    input  logic        loadByte,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic        store_q;
    logic        byte_store_q;
    logic        load_byte_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rd_data_q;
    logic        done_q;
    logic        err_q;

    logic             accept_d;
    logic [14:0]      word_addr_d;
    logic [AW-1:0]    idx_d;
    logic             oob_d;
    logic [1:0][7:0]  lane_rd_d;
    logic [7:0]       sel_byte_d;
    logic [15:0]      load_val_d;

    assign accept_d    = req_valid & (memRead | memWrite);
    assign word_addr_d = addr_q[15:1];
    assign idx_d       = AW'({17'd0, word_addr_d} % DEPTH);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob_d = ({17'd0, word_addr_d} >= DEPTH);
`else
    assign oob_d = 1'b0;
`endif

    // Each byte lane is its own array so byte stores never need a read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic       we_d;
            logic [7:0] wbyte_d;

            assign we_d    = rst && (state_q == ST_ACCESS) && store_q && !oob_d &&
                             (!byte_store_q || (addr_q[0] == 1'(gi)));
            assign wbyte_d = byte_store_q ? wdata_q[7:0] : wdata_q[8*gi +: 8];

            always_ff @(posedge clk) begin
                if (we_d) begin
                    mem_q[idx_d] <= wbyte_d;
                end
            end

            assign lane_rd_d[gi] = mem_q[idx_d];
        end
    endgenerate

    assign sel_byte_d = addr_q[0] ? lane_rd_d[1] : lane_rd_d[0];
    assign load_val_d = load_byte_q ? {{8{sel_byte_d[7]}}, sel_byte_d} : lane_rd_d;

    // Request fields are captured only on acceptance; later input changes have no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            rd_data_q <= 16'h0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        store_q      <= memWrite;
                        byte_store_q <= sByte;
                        load_byte_q  <= loadByte;
                        addr_q       <= addr;
                        wdata_q      <= wr_data;
                        if (LATENCY == 0) begin
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_WAIT;
                            count_q <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (count_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    done_q  <= 1'b1;
                    err_q   <= oob_d;
                    state_q <= ST_IDLE;
                    if (!store_q) begin
                        rd_data_q <= oob_d ? 16'h0000 : load_val_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_ACCESS);
    assign rd_data   = rd_data_q;
    assign done      = done_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a memory model and an expected-result queue.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        memRead;
    logic        memWrite;
    logic        sByte;
    logic        loadByte;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;
    logic        busy;
    logic        err;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .sByte     (sByte),
        .loadByte  (loadByte),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem_m [256];
    logic [15:0] rd_m;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: computes the response a request should produce and queues it.
    task automatic model_push(input logic rd, input logic wr, input logic sb, input logic lb,
                              input logic [15:0] a, input logic [15:0] d);
        logic [14:0] wi;
        logic [7:0]  mi;
        logic [7:0]  bt;
        logic        oob;
        exp_t        e;
        wi = a[15:1];
        mi = wi[7:0];
`ifdef DMEM_BOUNDS_CHECK_EN
        oob = (wi >= 15'd256);
`else
        oob = 1'b0;
`endif
        if (wr) begin
            if (!oob) begin
                if (!sb)      mem_m[mi]       = d;
                else if (a[0]) mem_m[mi][15:8] = d[7:0];
                else          mem_m[mi][7:0]  = d[7:0];
            end
        end else if (rd) begin
            if (oob) begin
                rd_m = 16'h0000;
            end else if (lb) begin
                bt   = a[0] ? mem_m[mi][15:8] : mem_m[mi][7:0];
                rd_m = {{8{bt[7]}}, bt};
            end else begin
                rd_m = mem_m[mi];
            end
        end
        e.rd  = rd_m;
        e.err = oob;
        sb_q.push_back(e);
    endtask

    task automatic do_op(input string name, input logic rd, input logic wr, input logic sb,
                         input logic lb, input logic [15:0] a, input logic [15:0] d);
        int   n;
        bit   got;
        exp_t e;
        @(negedge clk);
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; memRead = rd; memWrite = wr; sByte = sb; loadByte = lb;
        addr = a; wr_data = d;
        model_push(rd, wr, sb, lb, a, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        memRead   = 1'($urandom);
        memWrite  = 1'($urandom);
        sByte     = 1'($urandom);
        loadByte  = 1'($urandom);
        addr      = 16'($urandom);
        wr_data   = 16'($urandom);
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
            else chk({name, "_busy"}, 32'(busy), 32'd1);
        end
        chk({name, "_latency"}, 32'(n), 32'(LAT + 2));
        e = sb_q.pop_front();
        if (got) begin
            chk({name, "_rd_data"}, 32'(rd_data), 32'(e.rd));
            chk({name, "_err"}, 32'(err), 32'(e.err));
            chk({name, "_ready_at_done"}, 32'(req_ready), 32'd1);
        end
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        $display("txn %-12s rd=%0b wr=%0b sb=%0b lb=%0b addr=%h data=%h -> rd_data=%h err=%0b cycles=%0d",
                 name, rd, wr, sb, lb, a, d, rd_data, err, n);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        exp_t e;
        rst = 1'b0; req_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        sByte = 1'b0; loadByte = 1'b0; addr = 16'h0; wr_data = 16'h0;
        rd_m = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);

        // Word store/load, addr[0] ignored on word access
        do_op("st_beef", 0, 1, 0, 0, 16'h0010, 16'hBEEF);
        do_op("ld_w_11", 1, 0, 0, 0, 16'h0011, 16'h0000);
        chk("ld_w_11_const", 32'(rd_data), 32'hBEEF);

        // Byte store to upper lane, word and signed byte loads
        do_op("st_b_11", 0, 1, 1, 0, 16'h0011, 16'hA512);
        do_op("ld_w_10", 1, 0, 0, 0, 16'h0010, 16'h0000);
        chk("ld_w_10_const", 32'(rd_data), 32'h12EF);
        do_op("ld_b_10", 1, 0, 0, 1, 16'h0010, 16'h0000);
        chk("ld_b_10_const", 32'(rd_data), 32'hFFEF);
        do_op("ld_b_11", 1, 0, 0, 1, 16'h0011, 16'h0000);
        chk("ld_b_11_const", 32'(rd_data), 32'h0012);

        // Byte store to lower lane, 0x80 sign extension
        do_op("st_w_20", 0, 1, 0, 0, 16'h0020, 16'h3456);
        do_op("st_b_20", 0, 1, 1, 0, 16'h0020, 16'h7780);
        do_op("ld_b_20", 1, 0, 0, 1, 16'h0020, 16'h0000);
        chk("ld_b_20_const", 32'(rd_data), 32'hFF80);
        do_op("ld_w_20", 1, 0, 0, 0, 16'h0020, 16'h0000);
        chk("ld_w_20_const", 32'(rd_data), 32'h3480);

        // Read and write both set acts as a store and leaves rd_data alone
        do_op("rw_both", 1, 1, 0, 0, 16'h0030, 16'h7777);
        chk("rw_both_hold", 32'(rd_data), 32'h3480);
        do_op("ld_w_30", 1, 0, 0, 0, 16'h0030, 16'h0000);
        chk("ld_w_30_const", 32'(rd_data), 32'h7777);

        // req_valid with no operation is ignored
        @(negedge clk);
        req_valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = 16'h0010;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        req_valid = 1'b0;
        chk("noop_busy", 32'(busy_cnt), 32'd0);
        chk("noop_done", 32'(done_cnt), 32'd0);

        // Back-to-back loads with req_valid held: one accept every LAT+2 cycles
        @(negedge clk);
        req_valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; sByte = 1'b0; loadByte = 1'b0;
        addr = 16'h0010;
        repeat (3) model_push(1, 0, 0, 0, 16'h0010, 16'h0000);
        busy_cnt = 0;
        done_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 12) req_valid = 1'b0;
            chk($sformatf("b2b_busy_%0d", n), 32'(busy), 32'((n % 4) != 0));
            chk($sformatf("b2b_done_%0d", n), 32'(done), 32'((n % 4) == 0));
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk($sformatf("b2b_rd_%0d", n), 32'(rd_data), 32'(e.rd));
                end
            end
        end
        chk("b2b_busy_total", 32'(busy_cnt), 32'd9);
        chk("b2b_done_total", 32'(done_cnt), 32'd3);
        chk("b2b_queue_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        $display("txn b2b_loads  addr=0010 dones=%0d busy_cycles=%0d", done_cnt, busy_cnt);
        memRead = 1'b0;

        // Reset during WAIT aborts the store
        @(negedge clk);
        req_valid = 1'b1; memWrite = 1'b1; memRead = 1'b0; sByte = 1'b0;
        addr = 16'h0010; wr_data = 16'h1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0; memWrite = 1'b0;
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'h0);
        rst = 1'b1;
        rd_m = 16'h0000;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        $display("txn abort      addr=0010 data=1111 -> store dropped by reset");
        do_op("ld_after_abt", 1, 0, 0, 0, 16'h0010, 16'h0000);
        chk("ld_after_abt_const", 32'(rd_data), 32'h12EF);

        // Out-of-range word index
        do_op("st_w_00", 0, 1, 0, 0, 16'h0000, 16'h5A5A);
        do_op("ld_w_400", 1, 0, 0, 0, 16'h0400, 16'h0000);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("ld_w_400_const", 32'(rd_data), 32'h0000);
`else
        chk("ld_w_400_const", 32'(rd_data), 32'h5A5A);
`endif
        do_op("st_w_400", 0, 1, 0, 0, 16'h0400, 16'hDEAD);
        do_op("ld_w_00", 1, 0, 0, 0, 16'h0000, 16'h0000);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("ld_w_00_const", 32'(rd_data), 32'h5A5A);
`else
        chk("ld_w_00_const", 32'(rd_data), 32'hDEAD);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
